mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, physical byte-address width.
REQ-002 Parameter LINE_W, default 128, cache-line data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_read  input  1  instruction-cache line fill request.
REQ-006 i_address  input  ADDR_W  instruction fill line address.
REQ-007 i_rdata  output  LINE_W  fill data returned to instruction cache.
REQ-008 i_resp  output  1  instruction request complete, one-cycle pulse.
REQ-009 d_read  input  1  data-cache line fill request.
REQ-010 d_write  input  1  data-cache line writeback request.
REQ-011 d_address  input  ADDR_W  data request line address.
REQ-012 d_wdata  input  LINE_W  writeback data.
REQ-013 d_rdata  output  LINE_W  fill data returned to data cache.
REQ-014 d_resp  output  1  data request complete, one-cycle pulse.
REQ-015 pmem_read  output  1  physical memory read strobe.
REQ-016 pmem_write  output  1  physical memory write strobe.
REQ-017 pmem_address  output  ADDR_W  physical memory address.
REQ-018 pmem_wdata  output  LINE_W  physical memory write data.
REQ-019 pmem_rdata  input  LINE_W  physical memory read data.
REQ-020 pmem_resp  input  1  physical memory transaction done.

Function
REQ-021 FSM states: IDLE, SERVE_I, SERVE_D; encoded as a package enum.
REQ-022 IDLE: with no request pending, remain in IDLE; all pmem strobes low.
REQ-023 IDLE: on a pending request, select the winner (REQ-030/REQ-031) and enter SERVE_I or SERVE_D next cycle; latch address, operation and wdata into registers at that edge.
REQ-024 SERVE_x: drive pmem_read/pmem_write, pmem_address and pmem_wdata from the latched registers only; these stay stable for the whole transaction, regardless of requester input changes.
REQ-025 SERVE_x with pmem_resp=1: pulse the matching x_resp for that same cycle, pass pmem_rdata to x_rdata combinationally, and return to IDLE next cycle.
REQ-026 The non-served x_resp stays 0; x_rdata outputs are 0 whenever their x_resp is 0.
REQ-027 Minimum latency: request seen in IDLE at cycle N; pmem strobe at N+1; x_resp equals the cycle pmem_resp arrives, at earliest N+1.
REQ-028 At least one IDLE cycle occurs between consecutive transactions, so a requester that drops its request after x_resp is never re-granted spuriously.
REQ-029 d_read and d_write both high is illegal; the bench flags it; RTL treats it as a write.
REQ-030 Fixed priority (default build): when i_read and a data request are both pending in IDLE, the data request wins.
REQ-031 Requests asserted while in SERVE_x are not sampled until the next IDLE.
REQ-032 pmem_resp in IDLE is ignored, with no x_resp and no state change.

Reset
REQ-033 reset forces state IDLE, clears the latched address, wdata and operation to 0, and drives pmem_read=pmem_write=i_resp=d_resp=0, with immediate effect.
REQ-034 Reset mid-transaction abandons it; no x_resp is issued for it, and a late pmem_resp after reset release is ignored per REQ-032.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN: when defined, a last-grant flag (reset value = instruction) makes simultaneous requests go to the requester not granted last; when undefined, REQ-030 fixed data priority applies and the flag is absent.

Structure
REQ-036 arb_state_t enum and ADDR_W/LINE_W default constants reside in the shared lc3b_types package, alongside lc3b_word and the cache-block types.
REQ-037 One sub-module, arb_select, is natural: a combinational winner-select from the two requests and the last-grant flag; the FSM and registers stay in mem_arbiter.

Verification
REQ-038 i_read=1, i_address=16'h1230, pmem_resp after 3 cycles with rdata=128'hA5.. -> pmem_read=1 with address 16'h1230; i_resp is a one-cycle pulse carrying i_rdata=128'hA5..; d_resp=0.
REQ-039 i_read and d_read asserted in the same IDLE cycle (i_address=0x0040, d_address=0x0080), default build -> 0x0080 is served first, then after one IDLE cycle 0x0040.
REQ-040 Same as REQ-039 with ARB_ROUND_ROBIN_EN defined, after reset -> 0x0080 first; then another simultaneous pair -> instruction first.
REQ-041 d_write with d_wdata=128'hDEAD.., d_address changed to 0xFFFF mid-transaction -> pmem_address and pmem_wdata hold their original values; pmem_write=1; d_resp pulses once.
REQ-042 reset asserted while in SERVE_D, before pmem_resp -> strobes drop in the same cycle; a pmem_resp two cycles after release yields no d_resp.
REQ-043 pmem_resp=1 while in IDLE, with no requests -> no resp pulse; state stays IDLE.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, cache-block types and the memory arbiter
// state encoding / default widths.
package lc3b_types;

   localparam int unsigned ADDR_W_DEF  = 16;
   localparam int unsigned LINE_W_DEF  = 128;
   localparam int unsigned OFFSET_W    = 4;
   localparam int unsigned TAG_W       = ADDR_W_DEF - OFFSET_W - 3;

   typedef logic [15:0]           lc3b_word;
   typedef logic [LINE_W_DEF-1:0] lc3b_block;
   typedef logic [OFFSET_W-1:0]   lc3b_offset;
   typedef logic [TAG_W-1:0]      lc3b_tag;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2
   } arb_state_t;

   function automatic logic arb_serving(input arb_state_t s);
      return (s == ARB_SERVE_I) || (s == ARB_SERVE_D);
   endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner select between instruction and data fill requests.
// ARB_ROUND_ROBIN_EN adds the last-grant input; otherwise data has fixed priority.
module arb_select
   import lc3b_types::*;
(
   input  logic i_req,
   input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic last_d,
`endif
   output logic grant,
   output logic grant_d
);

   always_comb begin
      grant = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
      // On a tie, the side that did not win last time gets the grant.
      grant_d = d_req & (~i_req | ~last_d);
`else
      grant_d = d_req;
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) to single physical-memory arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break instead of fixed data priority.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic              write_q;
   logic              d_req;
   logic              grant;
   logic              grant_d;
   logic              latch_en;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_d_q;
`endif

   // A simultaneous read+write from the data side is treated as a write.
   always_comb d_req = d_read | d_write;

   arb_select u_sel (
      .i_req   (i_read),
      .d_req   (d_req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_d  (last_d_q),
`endif
      .grant   (grant),
      .grant_d (grant_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      latch_en  = 1'b0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (grant) begin
               latch_en  = 1'b1;
               state_nxt = grant_d ? ARB_SERVE_D : ARB_SERVE_I;
            end
         end
         ARB_SERVE_I: begin
            if (pmem_resp) begin
               i_resp    = 1'b1;
               state_nxt = ARB_IDLE;
            end
         end
         ARB_SERVE_D: begin
            if (pmem_resp) begin
               d_resp    = 1'b1;
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Transaction registers: loaded only on the IDLE grant edge, so the pmem
   // side never sees requester inputs change mid-transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else if (latch_en) begin
         if (grant_d) begin
            addr_q  <= d_address;
            wdata_q <= d_wdata;
            write_q <= d_write;
         end else begin
            addr_q  <= i_address;
            wdata_q <= '0;
            write_q <= 1'b0;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_d_q <= 1'b0;
      end else if (latch_en) begin
         last_d_q <= grant_d;
      end
   end
`endif

   always_comb begin
      pmem_read    = arb_serving(state) & ~write_q;
      pmem_write   = arb_serving(state) &  write_q;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      i_rdata      = i_resp ? pmem_rdata : '0;
      d_rdata      = d_resp ? pmem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam logic [127:0] PAT_A5   = {16{8'hA5}};
   localparam logic [127:0] PAT_DEAD = {8{16'hDEAD}};

   logic         clk;
   logic         reset;
   logic         i_read;
   logic [15:0]  i_address;
   logic [127:0] i_rdata;
   logic         i_resp;
   logic         d_read;
   logic         d_write;
   logic [15:0]  d_address;
   logic [127:0] d_wdata;
   logic [127:0] d_rdata;
   logic         d_resp;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   int unsigned cmp_count = 0;
   int unsigned err_count = 0;

   mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      cmp_count++;
      if (act !== exp) begin
         err_count++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Model: one outstanding transaction at most; a grant is taken only when idle.
   bit           m_busy;
   bit           m_is_d;
   bit           m_write;
   bit           m_last_d;
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;

   always @(negedge clk) begin
      bit ireq, dreq, pick_d;
      if (reset) begin
         m_busy = 0; m_is_d = 0; m_write = 0; m_last_d = 0;
         m_addr = '0; m_wdata = '0;
      end
      chk("pmem_read",  {127'd0, pmem_read},  {127'd0, m_busy && !m_write});
      chk("pmem_write", {127'd0, pmem_write}, {127'd0, m_busy && m_write});
      chk("i_resp", {127'd0, i_resp}, {127'd0, m_busy && !m_is_d && pmem_resp});
      chk("d_resp", {127'd0, d_resp}, {127'd0, m_busy && m_is_d && pmem_resp});
      chk("i_rdata", i_rdata, (m_busy && !m_is_d && pmem_resp) ? pmem_rdata : '0);
      chk("d_rdata", d_rdata, (m_busy && m_is_d && pmem_resp) ? pmem_rdata : '0);
      if (m_busy) chk("pmem_address", {112'd0, pmem_address}, {112'd0, m_addr});
      if (m_busy && m_write) chk("pmem_wdata", pmem_wdata, m_wdata);
      if (!reset) begin
         if (!m_busy) begin
            ireq = i_read;
            dreq = d_read || d_write;
            if (ireq || dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
               pick_d = dreq && (!ireq || !m_last_d);
`else
               pick_d = dreq;
`endif
               m_busy   = 1;
               m_is_d   = pick_d;
               m_last_d = pick_d;
               m_addr   = pick_d ? d_address : i_address;
               m_write  = pick_d && d_write;
               m_wdata  = d_wdata;
            end
         end else if (pmem_resp) begin
            m_busy = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
      i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      step(); step();
      at_neg();
      chk("reset_pmem_read",  {127'd0, pmem_read},  128'd0);
      chk("reset_pmem_write", {127'd0, pmem_write}, 128'd0);
      chk("reset_resp", {126'd0, i_resp, d_resp}, 128'd0);
      step();
      reset = 0;
      step();
   endtask

   task automatic pair_test(input bit d_first);
      logic [15:0] first_a, second_a;
      first_a  = d_first ? 16'h0080 : 16'h0040;
      second_a = d_first ? 16'h0040 : 16'h0080;
      i_read = 1; i_address = 16'h0040;
      d_read = 1; d_address = 16'h0080;
      step();
      if (d_first) d_read = 0; else i_read = 0;
      at_neg();
      chk("pair_first_addr", {112'd0, pmem_address}, {112'd0, first_a});
      chk("pair_first_read", {127'd0, pmem_read}, 128'd1);
      step(); step();
      pmem_resp = 1; pmem_rdata = rand128();
      at_neg();
      chk("pair_first_resp", {126'd0, d_resp, i_resp}, d_first ? 128'd2 : 128'd1);
      step();
      pmem_resp = 0;
      at_neg();
      chk("pair_idle_gap", {127'd0, pmem_read}, 128'd0);
      step();
      if (d_first) i_read = 0; else d_read = 0;
      at_neg();
      chk("pair_second_addr", {112'd0, pmem_address}, {112'd0, second_a});
      step();
      pmem_resp = 1; pmem_rdata = rand128();
      at_neg();
      chk("pair_second_resp", {126'd0, d_resp, i_resp}, d_first ? 128'd1 : 128'd2);
      step();
      pmem_resp = 0;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r;
      do_reset();

      // Single instruction fill with a three-cycle memory latency.
      i_read = 1; i_address = 16'h1230;
      step();
      i_read = 0;
      at_neg();
      chk("ifill_read", {127'd0, pmem_read}, 128'd1);
      chk("ifill_addr", {112'd0, pmem_address}, 128'h1230);
      chk("ifill_early_resp", {127'd0, i_resp}, 128'd0);
      step(); step();
      pmem_resp = 1; pmem_rdata = PAT_A5;
      at_neg();
      chk("ifill_resp", {127'd0, i_resp}, 128'd1);
      chk("ifill_rdata", i_rdata, PAT_A5);
      chk("ifill_d_resp", {127'd0, d_resp}, 128'd0);
      step();
      pmem_resp = 0;
      at_neg();
      chk("ifill_resp_pulse", {127'd0, i_resp}, 128'd0);
      chk("ifill_done_read", {127'd0, pmem_read}, 128'd0);
      step();

      do_reset();
      pair_test(1'b1);

      // Writeback whose requester inputs change under the transaction.
      d_write = 1; d_address = 16'h0100; d_wdata = PAT_DEAD;
      step();
      d_write = 0; d_address = 16'hFFFF; d_wdata = rand128();
      at_neg();
      chk("wb_write", {127'd0, pmem_write}, 128'd1);
      chk("wb_addr", {112'd0, pmem_address}, 128'h0100);
      chk("wb_wdata", pmem_wdata, PAT_DEAD);
      step(); step();
      pmem_resp = 1;
      at_neg();
      chk("wb_addr_hold", {112'd0, pmem_address}, 128'h0100);
      chk("wb_wdata_hold", pmem_wdata, PAT_DEAD);
      chk("wb_resp", {127'd0, d_resp}, 128'd1);
      step();
      pmem_resp = 0;
      at_neg();
      chk("wb_resp_once", {127'd0, d_resp}, 128'd0);
      step();

`ifdef ARB_ROUND_ROBIN_EN
      pair_test(1'b0);
`else
      pair_test(1'b1);
`endif

      // Reset in the middle of a data fill.
      d_read = 1; d_address = 16'h0200;
      step();
      d_read = 0;
      at_neg();
      chk("rst_pre_read", {127'd0, pmem_read}, 128'd1);
      step();
      #2;
      reset = 1;
      #1;
      chk("rst_strobe_drop", {126'd0, pmem_read, pmem_write}, 128'd0);
      at_neg();
      step();
      reset = 0;
      step(); step();
      pmem_resp = 1; pmem_rdata = rand128();
      at_neg();
      chk("rst_late_resp", {126'd0, d_resp, i_resp}, 128'd0);
      step();
      pmem_resp = 0;
      step();

      // Stray memory response while idle.
      pmem_resp = 1; pmem_rdata = rand128();
      at_neg();
      chk("idle_resp", {126'd0, d_resp, i_resp}, 128'd0);
      step();
      pmem_resp = 0;
      at_neg();
      chk("idle_stays", {126'd0, pmem_read, pmem_write}, 128'd0);
      step();

      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 249) == 0);
         i_read    = ($urandom_range(0, 2) == 0);
         i_address = 16'($urandom());
         r         = $urandom_range(0, 99);
         d_read    = (r < 25) || (r == 99);
         d_write   = ((r >= 25) && (r < 45)) || (r == 99);
         d_address = 16'($urandom());
         d_wdata   = rand128();
         pmem_resp = ($urandom_range(0, 99) < 35);
         pmem_rdata = rand128();
         if (d_read && d_write)
            $display("note: illegal d_read+d_write at %0t, modelled as a write", $time);
         step();
      end
      clear_inputs();
      reset = 0;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
